// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 4 requesters: registered grant index feeding a 2-to-4 decoder with enable.
// Optional per-owner hold limit with preemption when ARB_TIMEOUT_EN is defined (HOLD_MAX exists only then).
//   state | meaning
//   IDLE  | no grant issued; gnt_idx keeps the last owner
//   GRANT | requester gnt_idx owns the shared resource
module rr_dec_arbiter #(
    parameter int N_REQ = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int HOLD_MAX = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] others;
    logic [1:0]       pick_idle, pick_hand;
    logic             grant_new;
    logic             hold_expired;

    // First set bit of r scanning from+1, from+2, from+3, from+4 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = from + 2'(k);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] dec2to4(input logic ena, input logic [1:0] sel);
        logic [3:0] dec;
        dec = 4'b0000;
        if (ena) dec[sel] = 1'b1;
        return dec;
    endfunction

    assign others    = req & ~dec2to4(1'b1, idx_q);
    assign pick_idle = rr_pick(req, last_q);
    assign pick_hand = rr_pick(others, idx_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q;

    assign hold_expired = (hold_q == HOLD_LAST);

    // Saturates at the limit so a lone owner keeps its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 8'd0;
        end else if (state_d != GRANT || grant_new) begin
            hold_q <= 8'd0;
        end else if (!hold_expired) begin
            hold_q <= hold_q + 8'd1;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        grant_new = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && |req) begin
                    state_d   = GRANT;
                    idx_d     = pick_idle;
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!req[idx_q] || hold_expired) begin
                    if (|others) begin
                        idx_d     = pick_hand;
                        grant_new = 1'b1;
                    end else if (!req[idx_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_d = grant_new ? idx_d : last_q;
        gnt_d  = dec2to4(state_d == GRANT, idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign busy      = gnt_valid | (en & (|req));

endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Keeps a registered 2-bit grant index and drives a one-hot grant through a 2-to-4 decoder with enable. The arbiter supplies the index and the enable.
- Sits between the requesters and the shared resource's select or enable lines.
- A grant is held while its requester keeps its request high. The next grant follows circular priority.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 in this revision because the index is 2 bits.
- HOLD_MAX, 8, maximum consecutive grant cycles before preemption; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  arbiter enable; when low, no grant is issued.
- req  input  4  request vector; req[i] is held high by requester i for the whole time it uses the resource.
- gnt  output  4  one-hot grant, registered; equals decode(gnt_idx) when gnt_valid=1, otherwise 0.
- gnt_idx  output  2  index of the current or last granted requester, registered.
- gnt_valid  output  1  a grant is active.
- busy  output  1  high when gnt_valid=1 or req!=0 while en=1; combinational from state and inputs.

Behaviour:
- Reset, sampled at a clock edge with rst=1:
  - gnt=4'b0000, gnt_idx=2'd0, gnt_valid=0.
  - State goes to IDLE.
  - Priority pointer last=2'd3, so requester 0 has highest priority after reset.
  - Hold counter cleared.
- Reset mid-grant behaves identically: the grant drops at that edge and there is no completion cycle.
- Invariant: gnt is always 0 or exactly one-hot, with gnt[gnt_idx]=gnt_valid. Bench asserts this every cycle.
- States: IDLE (no grant), GRANT (one requester owns the resource).
- Priority search: winner = first i with req[i]=1, scanning indices last+1, last+2, last+3, last+4, all mod 4. The 2-bit index wraps 3->0.
- IDLE:
  - en=1 and req!=0: next edge sets gnt_idx=winner, gnt_valid=1, last=winner, state GRANT.
  - Latency: request sampled at edge k gives the grant visible right after edge k, i.e. one cycle.
  - Otherwise: stay in IDLE, outputs unchanged, gnt_idx keeps its last value.
- GRANT:
  - en=1 and req[gnt_idx]=1: hold; no output change; new requests from others are queued implicitly by remaining high.
  - req[gnt_idx]=0 with other requests pending: back-to-back handoff at the next edge, no bubble. The search runs with req[gnt_idx] masked, starting from last=gnt_idx.
  - req[gnt_idx]=0 with no other request: next edge gives gnt_valid=0, gnt=0, state IDLE; gnt_idx retained.
  - en=0 at any time: next edge gives gnt_valid=0, gnt=0, state IDLE. The pointer and gnt_idx are retained; the hold counter is cleared.
- Simultaneous events:
  - Owner drops its request in the same cycle a new request rises: the new request participates in that cycle's search.
  - rst has priority over en, and en has priority over requests.
- Requests that rise and fall while another requester owns the grant are lost; no latching. Requesters must hold req until granted.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter is cleared on each new grant and increments each cycle in GRANT.
  - When the counter reaches HOLD_MAX-1 and another request is pending (req with bit gnt_idx masked is non-zero), the next edge preempts: handoff to the round-robin winner exactly as on release.
  - If no other request is pending, the counter saturates and the grant holds.
  - The current owner keeps req high and re-competes normally.
- Not defined:
  - No counter is present.
  - A grant holds indefinitely while req[gnt_idx]=1 and en=1.

Test Plan:
- Reset then req=4'b1010, en=1 -> one cycle later gnt=4'b0010, gnt_idx=1, gnt_valid=1, busy=1.
- Hold req=4'b1010; drop req[1] (req=4'b1000) -> next edge gnt=4'b1000 with no zero cycle. Then req=0 -> next edge gnt=0, gnt_valid=0, gnt_idx stays 3.
- Fairness with req=4'b1111 held, each owner dropping its bit for one cycle after 2 granted cycles -> grant order 0,1,2,3,0.
- en=0 during grant to requester 2 -> next edge gnt=0. Then en=1 with req=4'b0101 -> grant goes to 0, since the search starts after last=2.
- rst=1 for one cycle during grant to requester 3, req=4'b1111 held -> gnt=0 at that edge; first edge after release grants requester 0.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> requester 0 granted 4 cycles, then requester 1 for 4, then 0. With req=4'b0001 only, requester 0 holds beyond 4 cycles.
